// File: rtl/fc_pkg.sv
// Shared types and helpers for the time-multiplexed fully-connected layer.
package fc_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StCompute,
      StAct,
      StOutput
   } fc_state_e;

   localparam logic ACT_MODE_NONE = 1'b0;
   localparam logic ACT_MODE_RELU = 1'b1;

   // Accumulator width that cannot overflow for num_inputs full-scale products.
   function automatic int unsigned acc_width(input int unsigned data_width,
                                             input int unsigned num_inputs);
      return 2 * data_width + $clog2(num_inputs);
   endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One MAC lane: accumulate x*w, then bias, rescale, saturate and activate.
module fc_mac_lane
   import fc_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned FRAC_BITS  = 12,
   parameter int unsigned ACC_WIDTH  = 42,
   parameter logic        ACT_MODE   = ACT_MODE_RELU
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clear,
   input  logic                         acc_en,
   input  logic                         finish,
   input  logic                         active,
   input  logic signed [DATA_WIDTH-1:0] x,
   input  logic signed [DATA_WIDTH-1:0] w,
   input  logic signed [DATA_WIDTH-1:0] bias,
   output logic signed [DATA_WIDTH-1:0] result
);

   localparam int unsigned SumW = ACC_WIDTH + 1;
   localparam logic signed [SumW-1:0] SatMax =
      {{(SumW - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
   localparam logic signed [SumW-1:0] SatMin =
      {{(SumW - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

   logic signed [2*DATA_WIDTH-1:0] prod;
   logic signed [ACC_WIDTH-1:0]    acc_q;
   logic signed [SumW-1:0]         biased;
   logic signed [SumW-1:0]         shifted;
   logic signed [DATA_WIDTH-1:0]   sat;
   logic signed [DATA_WIDTH-1:0]   act_out;

   assign prod = x * w;

   always_comb begin
      biased  = SumW'(acc_q) + (SumW'(bias) <<< FRAC_BITS);
      shifted = biased >>> FRAC_BITS;
      if (shifted > SatMax) begin
         sat = SatMax[DATA_WIDTH-1:0];
      end else if (shifted < SatMin) begin
         sat = SatMin[DATA_WIDTH-1:0];
      end else begin
         sat = shifted[DATA_WIDTH-1:0];
      end
      act_out = (ACT_MODE == ACT_MODE_RELU && sat[DATA_WIDTH-1]) ? '0 : sat;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q  <= '0;
         result <= '0;
      end else begin
         if (clear) begin
            acc_q <= '0;
         end else if (acc_en) begin
            acc_q <= acc_q + ACC_WIDTH'(prod);
         end
         // Lanes past the last neuron report zero.
         if (finish) begin
            result <= active ? act_out : '0;
         end
      end
   end

endmodule

// File: rtl/fc_layer_tm.sv
// Fully-connected layer: buffers one input vector, then evaluates LANES neurons per pass.
module fc_layer_tm
   import fc_pkg::*;
#(
   parameter int unsigned NUM_NEURONS = 30,
   parameter int unsigned NUM_INPUTS  = 784,
   parameter int unsigned LANES       = 4,
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned FRAC_BITS   = 12,
   parameter              ACT         = "relu"
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        weight_valid,
   input  logic [31:0]                 weight_value,
   input  logic                        bias_valid,
   input  logic [31:0]                 bias_value,
   input  logic [31:0]                 config_neuron_num,
   input  logic                        x_valid,
   input  logic [DATA_WIDTH-1:0]       x_in,
   output logic                        x_ready,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [LANES*DATA_WIDTH-1:0] out_data,
   output logic [31:0]                 out_base,
   output logic [LANES-1:0]            out_mask,
   output logic                        busy
);

   localparam int unsigned NumPasses = (NUM_NEURONS + LANES - 1) / LANES;
   localparam int unsigned AccW      = acc_width(DATA_WIDTH, NUM_INPUTS);
   localparam int unsigned IdxW      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
   localparam int unsigned CntW      = $clog2(NUM_INPUTS + 1);
   localparam int unsigned PassW     = (NumPasses > 1) ? $clog2(NumPasses) : 1;
   localparam int unsigned NeurW     = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
   localparam logic        ActMode   = (ACT == "none") ? ACT_MODE_NONE : ACT_MODE_RELU;

   fc_state_e        state_q, state_d;
   logic [IdxW-1:0]  xidx_q, xidx_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [PassW-1:0] pass_q, pass_d;
   logic [IdxW-1:0]  wptr_q, wptr_d, wptr_eff;
   logic [31:0]      cfg_q;
   logic             rd_vld_q;
   logic [IdxW-1:0]  rd_addr;
   logic             cfg_ok, wr_en, bias_en;
   logic [NeurW-1:0] cfg_sel;
   logic [LANES-1:0] lane_on;
   logic             unused_hi;

   logic signed [DATA_WIDTH-1:0] xbuf     [NUM_INPUTS];
   logic signed [DATA_WIDTH-1:0] wmem     [NUM_NEURONS][NUM_INPUTS];
   logic signed [DATA_WIDTH-1:0] bias_mem [NUM_NEURONS];
   logic signed [DATA_WIDTH-1:0] x_rd_q;

   assign unused_hi = ^{weight_value, bias_value};

   assign x_ready   = (state_q == StIdle) || (state_q == StLoad);
   assign busy      = (state_q != StIdle);
   assign out_valid = (state_q == StOutput);
   assign out_base  = 32'(pass_q) * LANES;

   // A change of target neuron restarts the weight write sequence at index 0.
   assign cfg_ok   = config_neuron_num < NUM_NEURONS;
   assign cfg_sel  = cfg_ok ? NeurW'(config_neuron_num) : '0;
   assign wptr_eff = (config_neuron_num != cfg_q) ? '0 : wptr_q;
   assign wr_en    = (state_q == StIdle) && weight_valid && cfg_ok;
   assign bias_en  = (state_q == StIdle) && bias_valid && cfg_ok;
   assign wptr_d   = !wr_en ? wptr_eff :
                     (wptr_eff == IdxW'(NUM_INPUTS - 1)) ? '0 : wptr_eff + IdxW'(1);
   assign rd_addr  = (cnt_q < CntW'(NUM_INPUTS)) ? cnt_q[IdxW-1:0] : '0;

   always_comb begin
      state_d = state_q;
      xidx_d  = xidx_q;
      cnt_d   = cnt_q;
      pass_d  = pass_q;
      unique case (state_q)
         StIdle, StLoad: begin
            if (x_valid) begin
               if (xidx_q == IdxW'(NUM_INPUTS - 1)) begin
                  xidx_d  = '0;
                  cnt_d   = '0;
                  pass_d  = '0;
                  state_d = StCompute;
               end else begin
                  xidx_d  = xidx_q + IdxW'(1);
                  state_d = StLoad;
               end
            end
         end
         StCompute: begin
            if (cnt_q == CntW'(NUM_INPUTS)) begin
               state_d = StAct;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StAct: state_d = StOutput;
         StOutput: begin
            if (out_ready) begin
               if (pass_q == PassW'(NumPasses - 1)) begin
                  pass_d  = '0;
                  state_d = StIdle;
               end else begin
                  pass_d  = pass_q + PassW'(1);
                  cnt_d   = '0;
                  state_d = StCompute;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         xidx_q   <= '0;
         cnt_q    <= '0;
         pass_q   <= '0;
         wptr_q   <= '0;
         cfg_q    <= '0;
         rd_vld_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         xidx_q   <= xidx_d;
         cnt_q    <= cnt_d;
         pass_q   <= pass_d;
         wptr_q   <= wptr_d;
         cfg_q    <= config_neuron_num;
         rd_vld_q <= (state_q == StCompute) && (cnt_q < CntW'(NUM_INPUTS));
      end
   end

   // Storage is deliberately left out of reset so weights survive a frame abort.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         wmem[cfg_sel][wptr_eff] <= weight_value[DATA_WIDTH-1:0];
      end
      if (bias_en) begin
         bias_mem[cfg_sel] <= bias_value[DATA_WIDTH-1:0];
      end
      if (x_ready && x_valid) begin
         xbuf[xidx_q] <= x_in;
      end
      x_rd_q <= xbuf[rd_addr];
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [31:0]                  neuron;
      logic [NeurW-1:0]             nsel;
      logic signed [DATA_WIDTH-1:0] w_rd_q;
      logic signed [DATA_WIDTH-1:0] res;

      assign neuron     = 32'(pass_q) * LANES + 32'(k);
      assign lane_on[k] = neuron < NUM_NEURONS;
      assign nsel       = lane_on[k] ? NeurW'(neuron) : '0;

      always_ff @(posedge clk) begin
         w_rd_q <= lane_on[k] ? wmem[nsel][rd_addr] : '0;
      end

      fc_mac_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .FRAC_BITS  (FRAC_BITS),
         .ACC_WIDTH  (AccW),
         .ACT_MODE   (ActMode)
      ) u_lane (
         .clk    (clk),
         .rst    (rst),
         .clear  ((state_q == StCompute) && (cnt_q == '0)),
         .acc_en (rd_vld_q),
         .finish (state_q == StAct),
         .active (lane_on[k]),
         .x      (x_rd_q),
         .w      (w_rd_q),
         .bias   (bias_mem[nsel]),
         .result (res)
      );

      assign out_data[k*DATA_WIDTH +: DATA_WIDTH] = res;
      assign out_mask[k] = out_valid && lane_on[k];
   end

endmodule

// File: tb/tb_fc_layer_tm.sv
// Bench for fc_layer_tm: relu and none instances in lockstep against an arithmetic model.
module tb_fc_layer_tm;

   localparam int NN = 5;
   localparam int NI = 4;
   localparam int LN = 2;
   localparam int DW = 16;
   localparam int FB = 8;
   localparam int NP = (NN + LN - 1) / LN;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic weight_valid = 1'b0, bias_valid = 1'b0, x_valid = 1'b0, out_ready = 1'b0;
   logic [31:0] weight_value = '0, bias_value = '0, config_neuron_num = '0;
   logic [DW-1:0] x_in = '0;

   logic x_ready_r, out_valid_r, busy_r, x_ready_n, out_valid_n, busy_n;
   logic [LN*DW-1:0] out_data_r, out_data_n;
   logic [31:0] out_base_r, out_base_n;
   logic [LN-1:0] out_mask_r, out_mask_n;

   int total = 0;
   int bad = 0;
   int rdy_mode = 0;

   always #5 clk = ~clk;

   fc_layer_tm #(
      .NUM_NEURONS(NN), .NUM_INPUTS(NI), .LANES(LN), .DATA_WIDTH(DW), .FRAC_BITS(FB),
      .ACT("relu")
   ) u_relu (
      .clk(clk), .rst(rst), .weight_valid(weight_valid), .weight_value(weight_value),
      .bias_valid(bias_valid), .bias_value(bias_value), .config_neuron_num(config_neuron_num),
      .x_valid(x_valid), .x_in(x_in), .x_ready(x_ready_r), .out_valid(out_valid_r),
      .out_ready(out_ready), .out_data(out_data_r), .out_base(out_base_r),
      .out_mask(out_mask_r), .busy(busy_r)
   );

   fc_layer_tm #(
      .NUM_NEURONS(NN), .NUM_INPUTS(NI), .LANES(LN), .DATA_WIDTH(DW), .FRAC_BITS(FB),
      .ACT("none")
   ) u_none (
      .clk(clk), .rst(rst), .weight_valid(weight_valid), .weight_value(weight_value),
      .bias_valid(bias_valid), .bias_value(bias_value), .config_neuron_num(config_neuron_num),
      .x_valid(x_valid), .x_in(x_in), .x_ready(x_ready_n), .out_valid(out_valid_n),
      .out_ready(out_ready), .out_data(out_data_n), .out_base(out_base_n),
      .out_mask(out_mask_n), .busy(busy_n)
   );

   // Model state: weights, biases, inputs and the write pointer rules.
   shortint m_w[NN][NI];
   shortint m_b[NN];
   shortint m_x[NI];
   int m_ptr = 0;
   int m_cfg_last = 0;

   typedef struct {
      logic [LN*DW-1:0] dr;
      logic [LN*DW-1:0] dn;
      int               base;
      logic [LN-1:0]    mask;
      bit               last;
   } grp_t;
   grp_t q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] m_neuron(input int n, input bit relu);
      longint s = 0;
      for (int i = 0; i < NI; i++) s += longint'(m_x[i]) * longint'(m_w[n][i]);
      s += longint'(m_b[n]) * (longint'(1) << FB);
      s = s >>> FB;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      if (relu && s < 0) s = 0;
      return 16'(s);
   endfunction

   function automatic void m_cfg(input int n);
      if (n != m_cfg_last) begin
         m_ptr = 0;
         m_cfg_last = n;
      end
   endfunction

   function automatic void m_weight(input int n, input logic [31:0] v);
      m_cfg(n);
      if (n < NN) begin
         m_w[n][m_ptr] = shortint'(v[15:0]);
         m_ptr = (m_ptr + 1) % NI;
      end
   endfunction

   function automatic void push_groups();
      for (int p = 0; p < NP; p++) begin
         grp_t g;
         g.base = p * LN;
         g.mask = '0;
         g.dr = '0;
         g.dn = '0;
         g.last = (p == NP - 1);
         for (int k = 0; k < LN; k++) begin
            int n;
            n = p * LN + k;
            if (n < NN) begin
               g.mask[k] = 1'b1;
               g.dr[k*DW +: DW] = m_neuron(n, 1'b1);
               g.dn[k*DW +: DW] = m_neuron(n, 1'b0);
            end
         end
         q.push_back(g);
      end
   endfunction

   function automatic logic [31:0] rnd32();
      int unsigned v;
      v = $urandom_range(0, 1) ? ($urandom_range(0, 1023) - 512) : $urandom_range(0, 65535);
      return {16'($urandom), 16'(v)};
   endfunction

   task automatic do_weight(input int n, input logic [31:0] v);
      config_neuron_num = n;
      weight_value = v;
      weight_valid = 1'b1;
      m_weight(n, v);
      @(posedge clk); #1;
      weight_valid = 1'b0;
   endtask

   task automatic do_bias(input int n, input logic [31:0] v);
      config_neuron_num = n;
      bias_value = v;
      bias_valid = 1'b1;
      m_cfg(n);
      if (n < NN) m_b[n] = shortint'(v[15:0]);
      @(posedge clk); #1;
      bias_valid = 1'b0;
   endtask

   task automatic load_all(input logic [31:0] w, input logic [31:0] b);
      for (int n = 0; n < NN; n++) begin
         for (int i = 0; i < NI; i++) do_weight(n, w);
         do_bias(n, b);
      end
   endtask

   // Co-write (optional) lands in the same IDLE cycle as the first sample.
   task automatic send_frame(input bit expect_out, input int gap_max, input bit co_en,
                             input int co_n, input logic [31:0] co_v);
      if (co_en) m_weight(co_n, co_v);
      if (expect_out) push_groups();
      for (int i = 0; i < NI; i++) begin
         repeat ($urandom_range(0, gap_max)) begin
            @(posedge clk); #1;
         end
         x_valid = 1'b1;
         x_in = m_x[i];
         if (co_en && i == 0) begin
            config_neuron_num = co_n;
            weight_value = co_v;
            weight_valid = 1'b1;
         end
         @(negedge clk);
         chk("x_ready_load", x_ready_r, 1);
         @(posedge clk); #1;
         x_valid = 1'b0;
         weight_valid = 1'b0;
      end
   endtask

   task automatic wait_done();
      int n;
      for (n = 0; n < 400; n++) begin
         @(posedge clk); #1;
         if (q.size() == 0 && !busy_r) break;
      end
      if (n == 400) begin
         chk("frame_timeout", q.size(), 0);
         q.delete();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      m_ptr = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid_r, 0);
      chk("rst_out_data", out_data_r, 0);
      chk("rst_out_base", out_base_r, 0);
      chk("rst_out_mask", out_mask_r, 0);
      chk("rst_busy", busy_r, 0);
      chk("rst_x_ready", x_ready_r, 1);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin : rdy_drv
      int hold;
      hold = 0;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 2) != 0);
            default: begin
               if (out_valid_r && hold < 5) begin
                  out_ready = 1'b0;
                  hold++;
               end else begin
                  out_ready = 1'b1;
                  if (!out_valid_r) hold = 0;
               end
            end
         endcase
      end
   end

   // Checks every OUTPUT cycle against the model queue, plus handshake hold and latency.
   initial begin : cmp
      int cyc, entry, xcnt;
      bit pv, pr;
      grp_t g;
      cyc = 0;
      entry = -1000;
      xcnt = 0;
      pv = 0;
      pr = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            xcnt = 0;
            pv = 0;
            pr = 0;
         end else begin
            if (x_valid && x_ready_r) begin
               xcnt++;
               if (xcnt == NI) begin
                  xcnt = 0;
                  entry = cyc + 1;
               end
            end
            if (out_valid_r) begin
               if (q.size() == 0) begin
                  chk("spurious_valid", out_valid_r, 0);
               end else begin
                  g = q[0];
                  if (!pv) chk("latency", cyc - entry, NI + 2);
                  chk("data_relu", out_data_r, g.dr);
                  chk("data_none", out_data_n, g.dn);
                  chk("base", out_base_r, g.base);
                  chk("mask", out_mask_r, g.mask);
                  chk("valid_none", out_valid_n, 1);
                  chk("busy_out", busy_r, 1);
                  if (out_ready) begin
                     void'(q.pop_front());
                     if (!g.last) entry = cyc + 1;
                  end
               end
            end else if (pv && !pr) begin
               chk("valid_held", out_valid_r, 1);
            end
            pv = out_valid_r;
            pr = out_ready;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin : main
      int n;
      do_reset();

      // Unit weights and inputs: every neuron sums to 4.0.
      load_all(32'h0000_0100, 32'h0);
      for (int i = 0; i < NI; i++) m_x[i] = 16'sh0100;
      chk("pin_unit", m_neuron(0, 1'b1), 16'h0400);
      chk("pin_unit_last", m_neuron(NN - 1, 1'b0), 16'h0400);
      send_frame(1'b1, 0, 1'b0, 0, 0);
      chk("pin_mask_last", q[NP-1].mask, 2'b01);
      chk("pin_base_last", q[NP-1].base, 4);
      wait_done();

      // Consumer stalls 5 cycles per group.
      rdy_mode = 2;
      send_frame(1'b1, 1, 1'b0, 0, 0);
      wait_done();
      rdy_mode = 0;

      // Saturation.
      load_all(32'h0000_7F00, 32'h0);
      for (int i = 0; i < NI; i++) m_x[i] = 16'sh7F00;
      chk("pin_sat", m_neuron(2, 1'b1), 16'h7FFF);
      send_frame(1'b1, 0, 1'b0, 0, 0);
      wait_done();

      // Negative bias through both activation modes.
      load_all(32'h0, 32'h0000_FF00);
      chk("pin_relu_neg", m_neuron(1, 1'b1), 16'h0000);
      chk("pin_none_neg", m_neuron(1, 1'b0), 16'hFF00);
      send_frame(1'b1, 0, 1'b0, 0, 0);
      wait_done();

      // Abort on the second COMPUTE cycle, then rerun without reloading.
      load_all(32'h0000_0100, 32'h0);
      for (int i = 0; i < NI; i++) m_x[i] = 16'sh0100;
      send_frame(1'b0, 0, 1'b0, 0, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_busy", busy_r, 0);
      chk("abort_out_valid", out_valid_r, 0);
      chk("abort_x_ready", x_ready_r, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      m_ptr = 0;
      send_frame(1'b1, 0, 1'b0, 0, 0);
      wait_done();

      // Strobes during COMPUTE must be ignored.
      send_frame(1'b1, 0, 1'b0, 0, 0);
      weight_valid = 1'b1;
      weight_value = 32'h0000_1234;
      bias_valid = 1'b1;
      bias_value = 32'h0000_1234;
      x_valid = 1'b1;
      x_in = 16'h1234;
      @(negedge clk);
      chk("compute_x_ready", x_ready_r, 0);
      chk("compute_busy", busy_r, 1);
      @(posedge clk); #1;
      weight_valid = 1'b0;
      bias_valid = 1'b0;
      x_valid = 1'b0;
      wait_done();
      send_frame(1'b1, 0, 1'b0, 0, 0);
      wait_done();

      // Random writes (pointer restarts, wrap, discarded neurons) and random frames.
      rdy_mode = 1;
      for (int f = 0; f < 8; f++) begin
         repeat (6) begin
            n = $urandom_range(0, NN + 1);
            repeat ($urandom_range(1, 6)) do_weight(n, rnd32());
            if ($urandom_range(0, 1) != 0) do_bias(n, rnd32());
         end
         for (int i = 0; i < NI; i++) m_x[i] = shortint'(rnd32());
         if (f % 2 == 1) begin
            send_frame(1'b1, 2, 1'b1, $urandom_range(0, NN - 1), rnd32());
         end else begin
            send_frame(1'b1, 2, 1'b0, 0, 0);
         end
         wait_done();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fc_layer_tm.md
FC_LAYER_TM -- requirements
Module: fc_layer_tm

Interface
REQ-001 SHALL take parameter NUM_NEURONS, default 30: neurons in the layer.
REQ-002 SHALL take parameter NUM_INPUTS, default 784: inputs (and weights) per neuron.
REQ-003 SHALL take parameter LANES, default 4: parallel MAC lanes; NUM_NEURONS need not be a multiple of LANES.
REQ-004 SHALL take parameter DATA_WIDTH, default 16: signed fixed-point data, weight and bias width.
REQ-005 SHALL take parameter FRAC_BITS, default 12: fractional bits of data, weight and bias.
REQ-006 SHALL take parameter ACT, default "relu": "relu" or "none".
REQ-007 SHALL have one clock and a synchronous, active-high reset: clk  in  1  clock; rst  in  1  reset.
REQ-008 weight_valid  in  1  weight write strobe; weight_value  in  32  weight (low DATA_WIDTH bits used).
REQ-009 bias_valid  in  1  bias write strobe; bias_value  in  32  bias (low DATA_WIDTH bits used).
REQ-010 config_neuron_num  in  32  target neuron of weight/bias writes.
REQ-011 x_valid  in  1  input strobe; x_in  in  DATA_WIDTH  input sample; x_ready  out  1  input accepted when high.
REQ-012 out_valid  out  1  output group valid; out_ready  in  1  consumer accepts group.
REQ-013 out_data  out  LANES*DATA_WIDTH  lane k in bits [k*DATA_WIDTH +: DATA_WIDTH]; out_base  out  32  neuron index of lane 0; out_mask  out  LANES  lanes holding real neurons.
REQ-014 busy  out  1  high in any state except IDLE.

Function
REQ-015 FSM states: IDLE, LOAD, COMPUTE, ACT, OUTPUT.
REQ-016 IDLE: x_ready=1; first x_valid stores x_in at buffer index 0 and moves to LOAD.
REQ-017 LOAD: x_ready=1; each x_valid stores next sample; after NUM_INPUTS-th sample moves to COMPUTE with pass=0.
REQ-018 COMPUTE, x_ready=0: weight RAM read has 1-cycle latency; lane k accumulates x[i]*w[pass*LANES+k][i] for i=0..NUM_INPUTS-1; state lasts NUM_INPUTS+1 cycles, then ACT.
REQ-019 Products are 2*DATA_WIDTH signed; accumulator is 2*DATA_WIDTH+clog2(NUM_INPUTS) bits, no overflow possible.
REQ-020 ACT (1 cycle): add bias sign-extended and shifted left FRAC_BITS; arithmetic shift right FRAC_BITS; saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; if ACT="relu", negative results become 0.
REQ-021 OUTPUT: out_valid=1, out_data/out_base/out_mask stable until out_valid&&out_ready; transfer then goes to COMPUTE with pass+1, or to IDLE after the last pass.
REQ-022 Pass count SHALL be ceil(NUM_NEURONS/LANES); lanes at or beyond NUM_NEURONS have out_mask bit 0 and out_data lane 0.
REQ-023 out_valid SHALL rise exactly NUM_INPUTS+2 cycles after COMPUTE entry for each pass.
REQ-024 Weight writes: accepted only in IDLE; each weight_valid writes weight_value to neuron config_neuron_num at write pointer, then pointer increments, wrapping at NUM_INPUTS.
REQ-025 Write pointer clears to 0 when config_neuron_num changes value; config_neuron_num >= NUM_NEURONS discards the write.
REQ-026 Bias writes: accepted only in IDLE; bias_valid stores bias of neuron config_neuron_num.
REQ-027 Weight/bias strobes outside IDLE, and x_valid while x_ready=0, are ignored without effect.
REQ-028 weight_valid and x_valid in the same IDLE cycle: both take effect.

Reset
REQ-029 rst at any cycle, including mid-LOAD/COMPUTE/OUTPUT, returns FSM to IDLE the next cycle, abandoning the frame.
REQ-030 Reset values: out_valid=0, out_data=0, out_base=0, out_mask=0, busy=0, x_ready=1, pass=0, input index=0, write pointer=0.
REQ-031 Weight RAM, bias registers and input buffer SHALL NOT be cleared by rst.

Structure
REQ-032 Shared package fc_pkg holds the FSM state enum, activation-mode constants and the accumulator-width function.
REQ-033 One sub-module fc_mac_lane (multiply, accumulate, bias, shift, saturate, activate), instantiated LANES times.

Verification
REQ-034 Bench params NUM_NEURONS=5, NUM_INPUTS=4, LANES=2, DATA_WIDTH=16, FRAC_BITS=8: all weights 0x0100, bias 0, inputs 0x0100 -> three groups, each lane 0x0400; out_base 0,2,4; out_mask 11,11,01.
REQ-035 Weights 0x7F00, inputs 0x7F00, bias 0 -> every valid lane saturates to 0x7FFF.
REQ-036 Weights 0, bias 0xFF00 (-1.0), ACT="relu" -> 0x0000; ACT="none" -> 0xFF00.
REQ-037 out_ready held low 5 cycles in OUTPUT -> out_valid and out_data stable all 5 cycles; next pass starts after handshake.
REQ-038 rst asserted on second COMPUTE cycle -> next cycle IDLE, busy=0, out_valid=0; rerun the REQ-034 frame without reloading weights -> identical outputs.
REQ-039 weight_valid pulsed during COMPUTE with value 0x1234 -> weights unchanged, next frame outputs unchanged.
